// File: rtl/att_arb_pkg.sv
// Shared types and grant-selection helpers for the Q/K/V projection arbiter.
package att_arb_pkg;

    typedef enum logic [1:0] {SEL_Q = 2'd0, SEL_K = 2'd1, SEL_V = 2'd2} att_sel_t;
    typedef enum logic {ST_IDLE, ST_BURST} att_arb_state_t;

    // Round-robin: search starts just after the previous owner and wraps V->Q.
    // Only meaningful when at least one request bit is set.
    function automatic att_sel_t rr_pick(input att_sel_t last, input logic [2:0] req);
        att_sel_t pick;
        unique case (last)
            SEL_Q:   pick = req[1] ? SEL_K : (req[2] ? SEL_V : SEL_Q);
            SEL_K:   pick = req[2] ? SEL_V : (req[0] ? SEL_Q : SEL_K);
            default: pick = req[0] ? SEL_Q : (req[1] ? SEL_K : SEL_V);
        endcase
        return pick;
    endfunction

    function automatic att_sel_t prio_pick(input logic [2:0] req);
        return req[0] ? SEL_Q : (req[1] ? SEL_K : SEL_V);
    endfunction

endpackage

// File: rtl/att_arb_out_reg.sv
// One-entry valid/ready pipeline register carrying beat data, source select and job-done flag.
// Latency 1 cycle; free_o is high when empty or draining this cycle, so a full entry stalls upstream.
module att_arb_out_reg
    import att_arb_pkg::*;
#(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] dat_i,
    input  att_sel_t     sel_i,
    input  logic         done_i,
    input  logic         ready_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o,
    output att_sel_t     sel_o,
    output logic         done_o,
    output logic         free_o
);

    logic         vld_q;
    logic [W-1:0] dat_q;
    att_sel_t     sel_q;
    logic         done_q;

    assign free_o = !vld_q || ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            sel_q  <= SEL_Q;
            done_q <= 1'b0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            dat_q  <= dat_i;
            sel_q  <= sel_i;
            done_q <= done_i;
        end else if (ready_i) begin
            // data and sel keep their last value; only the qualifiers drop
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end
    end

    assign vld_o  = vld_q;
    assign dat_o  = dat_q;
    assign sel_o  = sel_q;
    assign done_o = done_q;

endmodule

// File: rtl/att_proj_arbiter.sv
// Grants one shared projection matmul to Q, K or V for whole JOB_BEATS jobs (round-robin, or fixed Q>K>V with ATT_ARB_FIXED_PRIO_EN).
// Latency: valid seen in IDLE at t -> ready at t+1 -> data_out_valid at t+2; one IDLE bubble per job.
// Backpressure: granted ready = BURST && output register free, so data_out_ready stalls the source combinationally.
module att_proj_arbiter
    import att_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM     = 9,
    parameter int JOB_BEATS  = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH*IN_NUM-1:0] data_in_q,
    input  logic                         data_in_q_valid,
    output logic                         data_in_q_ready,
    input  logic [DATA_WIDTH*IN_NUM-1:0] data_in_k,
    input  logic                         data_in_k_valid,
    output logic                         data_in_k_ready,
    input  logic [DATA_WIDTH*IN_NUM-1:0] data_in_v,
    input  logic                         data_in_v_valid,
    output logic                         data_in_v_ready,
    output logic [DATA_WIDTH*IN_NUM-1:0] data_out,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic [1:0]                   data_out_sel,
    output logic                         job_done
);

    localparam int BW = DATA_WIDTH * IN_NUM;
    localparam int CW = (JOB_BEATS > 1) ? $clog2(JOB_BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(JOB_BEATS - 1);

    att_arb_state_t state_q, state_d;
    att_sel_t       grant_q, grant_d;
    att_sel_t       last_grant_q, last_grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [2:0]    req;
    logic          out_free;
    logic          burst_rdy;
    logic          sel_vld;
    logic [BW-1:0] sel_dat;
    logic          accept;
    logic          is_last;
    att_sel_t      out_sel;

    assign req       = {data_in_v_valid, data_in_k_valid, data_in_q_valid};
    assign burst_rdy = (state_q == ST_BURST) && out_free;

    assign data_in_q_ready = burst_rdy && (grant_q == SEL_Q);
    assign data_in_k_ready = burst_rdy && (grant_q == SEL_K);
    assign data_in_v_ready = burst_rdy && (grant_q == SEL_V);

    always_comb begin
        sel_vld = data_in_v_valid;
        sel_dat = data_in_v;
        unique case (grant_q)
            SEL_Q: begin
                sel_vld = data_in_q_valid;
                sel_dat = data_in_q;
            end
            SEL_K: begin
                sel_vld = data_in_k_valid;
                sel_dat = data_in_k;
            end
            default: ;
        endcase
    end

    assign accept  = burst_rdy && sel_vld;
    assign is_last = (cnt_q == LAST_BEAT);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
`ifdef ATT_ARB_FIXED_PRIO_EN
                    grant_d = prio_pick(req);
`else
                    grant_d = rr_pick(last_grant_q, req);
`endif
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // grant stays locked until the last beat, even across valid gaps
                if (accept) begin
                    if (is_last) begin
                        cnt_d        = '0;
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= SEL_Q;
            last_grant_q <= SEL_V;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    att_arb_out_reg #(
        .W (BW)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (accept),
        .dat_i   (sel_dat),
        .sel_i   (grant_q),
        .done_i  (is_last),
        .ready_i (data_out_ready),
        .vld_o   (data_out_valid),
        .dat_o   (data_out),
        .sel_o   (out_sel),
        .done_o  (job_done),
        .free_o  (out_free)
    );

    assign data_out_sel = out_sel;

endmodule

// File: tb/tb_att_proj_arbiter.sv
// Directed and random bench for att_proj_arbiter against a beats-remaining job model.
module tb_att_proj_arbiter;
    import att_arb_pkg::*;

    localparam int DW = 8;
    localparam int NUM = 9;
    localparam int JB = 6;
    localparam int BW = DW * NUM;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] d_i [3];
    logic [2:0]    v_i = 3'b000;
    logic          rdy_q, rdy_k, rdy_v;
    logic [2:0]    rdy;
    logic [BW-1:0] dout;
    logic          dout_vld;
    logic          dor = 1'b0;
    logic [1:0]    dout_sel;
    logic          done;

    always #5 clk = ~clk;
    assign rdy = {rdy_v, rdy_k, rdy_q};

    att_proj_arbiter #(
        .DATA_WIDTH (DW),
        .IN_NUM     (NUM),
        .JOB_BEATS  (JB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_in_q       (d_i[0]),
        .data_in_q_valid (v_i[0]),
        .data_in_q_ready (rdy_q),
        .data_in_k       (d_i[1]),
        .data_in_k_valid (v_i[1]),
        .data_in_k_ready (rdy_k),
        .data_in_v       (d_i[2]),
        .data_in_v_valid (v_i[2]),
        .data_in_v_ready (rdy_v),
        .data_out        (dout),
        .data_out_valid  (dout_vld),
        .data_out_ready  (dor),
        .data_out_sel    (dout_sel),
        .job_done        (done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: job owner with a countdown of beats left, plus the output slot.
    bit            m_busy;
    int            m_owner, m_left, m_last;
    bit            m_ovld;
    logic [BW-1:0] m_odat;
    int            m_osel;
    bit            m_odone;

    // Per-cycle observations handed back to the directed steps.
    bit            fire_o, fdone_o, ovld_o;
    logic [1:0]    fsel_o;
    logic [BW-1:0] cap_dat;
    logic [2:0]    acc_o, rdy_o;
    int            cyc = 0;

    int            n, prev, t_rdy, t_vld, qacc, hold, kbad, bad_qv;
    bit            seen;
    logic [BW-1:0] held;
    logic [2:0]    qv3;
    int            jobs [$];

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[BW-1:0];
    endfunction

    function automatic int pick(input logic [2:0] req);
        int s;
        int p;
        p = -1;
`ifdef ATT_ARB_FIXED_PRIO_EN
        for (int i = 2; i >= 0; i--)
            if (req[i]) p = i;
`else
        for (int i = 3; i >= 1; i--) begin
            s = (m_last + i) % 3;
            if (req[s]) p = s;
        end
`endif
        return p;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_left  = 0;
        m_last  = 2;
        m_ovld  = 0;
        m_odat  = '0;
        m_osel  = 0;
        m_odone = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", dout_vld, 0);
        chk("rst_job_done", done, 0);
        chk("rst_out_sel", dout_sel, 0);
        chk("rst_out_data", dout, 0);
        chk("rst_readies", rdy, 0);
        model_reset();
        @(negedge clk);
        v_i = 3'b000;
        rst = 1'b1;
    endtask

    task automatic cycle(input logic [2:0] vld, input logic ordy);
        bit ofree, acc;
        int p;
        @(negedge clk);
        v_i = vld;
        dor = ordy;
        for (int s = 0; s < 3; s++) d_i[s] = rnd();
        #1;
        ofree = !m_ovld || ordy;
        for (int s = 0; s < 3; s++)
            chk($sformatf("ready_%0d", s), rdy[s], m_busy && (m_owner == s) && ofree);
        chk("out_valid", dout_vld, m_ovld);
        if (m_ovld) begin
            chk("out_data", dout, m_odat);
            chk("out_sel", dout_sel, m_osel);
            chk("job_done", done, m_odone);
        end
        fire_o  = dout_vld && ordy;
        fsel_o  = dout_sel;
        fdone_o = done;
        ovld_o  = dout_vld;
        cap_dat = dout;
        rdy_o   = rdy;
        acc_o   = rdy & vld;
        acc = m_busy && ofree && vld[m_owner];
        if (acc) begin
            m_ovld  = 1;
            m_odat  = d_i[m_owner];
            m_osel  = m_owner;
            m_odone = (m_left == 1);
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end else begin
            if (ordy) begin
                m_ovld  = 0;
                m_odone = 0;
            end
            if (!m_busy) begin
                p = pick(vld);
                if (p >= 0) begin
                    m_busy  = 1;
                    m_owner = p;
                    m_left  = JB;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) d_i[s] = '0;
        model_reset();

        // All streams requesting, no backpressure: rotation, done pulses, one bubble per job.
        do_reset();
        n = 0;
        prev = 0;
        for (int k = 0; k < 80 && n < 24; k++) begin
            cycle(3'b111, 1'b1);
            if (fire_o) begin
`ifdef ATT_ARB_FIXED_PRIO_EN
                chk("t1_sel", fsel_o, 0);
`else
                chk("t1_sel", fsel_o, (n / JB) % 3);
`endif
                chk("t1_done", fdone_o, (n % JB) == JB - 1);
                if (n > 0) chk("t1_gap", cyc - prev, (n % JB == 0) ? 2 : 1);
                prev = cyc;
                n++;
            end
        end
        chk("t1_beats", n, 24);

        // Only K requesting: ready one cycle after valid, output valid one later.
        do_reset();
        t_rdy = -1;
        t_vld = -1;
        bad_qv = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(3'b010, 1'b1);
            if (rdy_o[1] && t_rdy < 0) t_rdy = k;
            if (ovld_o && t_vld < 0) t_vld = k;
            if (rdy_o[0] || rdy_o[2]) bad_qv++;
        end
        chk("t2_ready_lat", t_rdy, 1);
        chk("t2_valid_lat", t_vld, 2);
        chk("t2_qv_ready", bad_qv, 0);

        // Output stall mid-burst holds data and freezes the job.
        do_reset();
        n = 0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            cycle(3'b001, 1'b1);
            if (fire_o) n++;
        end
        held = '0;
        for (int k = 0; k < 3; k++) begin
            cycle(3'b001, 1'b0);
            if (k == 0) held = cap_dat;
            else chk("t3_hold_data", cap_dat, held);
            chk("t3_stall_valid", ovld_o, 1);
            chk("t3_stall_sel", fsel_o, 0);
            chk("t3_stall_ready", rdy_o[0], 0);
        end
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle(3'b001, 1'b1);
            if (k == 0) chk("t3_release_data", cap_dat, held);
            if (fire_o) begin
                n++;
                if (fdone_o) seen = 1;
            end
        end
        chk("t3_job_beats", n, JB);

        // Granted Q pauses after 3 beats; K must wait until Q finishes its job.
        do_reset();
        qacc = 0;
        hold = 0;
        kbad = 0;
        jobs.delete();
        for (int k = 0; k < 60 && jobs.size() < 2; k++) begin
            qv3 = {1'b0, 1'b1, (qacc != 3 || hold >= 4) && qacc < JB};
            cycle(qv3, 1'b1);
            if (qacc == 3) hold++;
            if (acc_o[0]) qacc++;
            if (acc_o[1] && qacc < JB) kbad++;
            if (fire_o && fdone_o) jobs.push_back(int'(fsel_o));
        end
        chk("t4_jobs", jobs.size(), 2);
        if (jobs.size() == 2) begin
            chk("t4_first_job", jobs[0], 0);
            chk("t4_second_job", jobs[1], 1);
        end
        chk("t4_k_early", kbad, 0);

        // Reset in the middle of a V job, then Q wins first.
        do_reset();
        n = 0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            cycle(3'b100, 1'b1);
            if (fire_o) begin
                chk("t5_v_sel", fsel_o, 2);
                n++;
            end
        end
        chk("t5_v_beats", n, 2);
        do_reset();
        n = 0;
        for (int k = 0; k < 20 && n < JB; k++) begin
            cycle(3'b111, 1'b1);
            if (fire_o) begin
                chk("t5_q_sel", fsel_o, 0);
                chk("t5_q_done", fdone_o, n == JB - 1);
                n++;
            end
        end
        chk("t5_q_beats", n, JB);

        // Random valids and backpressure against the model.
        do_reset();
        for (int k = 0; k < 1500; k++)
            cycle(3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
